// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks take priority; mul/div
// results queue in a small in-order buffer and drain into free write slots.
// Buffered results overtaken by a younger pipeline write to the same register
// are cancelled (live bit cleared) and later discarded without a write.
module wb_write_arbiter #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 5,
    parameter int DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en,
    input  logic [ADDR_LEN-1:0]        wb_reg,
    input  logic [WORD_LEN-1:0]        wb_data,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [ADDR_LEN-1:0]        md_reg,
    input  logic [WORD_LEN-1:0]        md_data,
    output logic                       writeEn,
    output logic [ADDR_LEN-1:0]        writereg,
    output logic [WORD_LEN-1:0]        writeData,
    output logic [$clog2(DEPTH):0]     md_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Buffer storage and bookkeeping
    logic [ADDR_LEN-1:0] reg_q  [DEPTH];
    logic [WORD_LEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]    live_q, live_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;

    // Registered write port
    logic                wr_en_q, wr_en_d;
    logic [ADDR_LEN-1:0] wr_reg_q, wr_reg_d;
    logic [WORD_LEN-1:0] wr_data_q, wr_data_d;

    logic head_present;
    logic head_live;
    logic case_a;
    logic case_b;
    logic pop;
    logic push;

    // Ready reflects occupancy before the edge only, so a same-edge pop never
    // opens the handshake early.
    assign md_ready = !rst && (count_q < DEPTH_C);

    assign head_present = (count_q != '0);
    assign head_live    = live_q[head_q];
    assign case_a       = wb_en && (wb_reg != '0);
    assign case_b       = !case_a && head_present && head_live;
    // A dead head is discarded even while the pipeline owns the port.
    assign pop          = head_present && (!head_live || case_b);
    // Results for register 0 complete the handshake but are never stored.
    assign push         = md_valid && md_ready && (md_reg != '0);

    // Next-state for issue decision, kill, pointers and occupancy
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        live_d    = live_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (case_a) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = wb_reg;
            wr_data_d = wb_data;
            // Only entries resident before this edge are killed; a same-edge
            // push is applied afterwards and overrides this.
            for (int i = 0; i < DEPTH; i++) begin
                if (reg_q[i] == wb_reg) begin
                    live_d[i] = 1'b0;
                end
            end
        end else if (case_b) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = reg_q[head_q];
            wr_data_d = data_q[head_q];
        end

        if (pop) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PW'(1);
        end

        if (push) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State and write-port registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            live_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            live_q    <= live_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Payload storage, written at the tail on each accepted push
    always_ff @(posedge clk) begin
        // NOTE: payload memory is not reset; the live bits and count decide what is valid.
        if (push) begin
            reg_q[tail_q]  <= md_reg;
            data_q[tail_q] <= md_data;
        end
    end

    assign writeEn   = wr_en_q;
    assign writereg  = wr_reg_q;
    assign writeData = wr_data_q;
    assign md_count  = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (default parameters).
module tb_wb_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        writeEn;
    logic [4:0]  writereg;
    logic [31:0] writeData;
    logic [1:0]  md_count;

    int checks = 0;
    int errors = 0;

    wb_write_arbiter #(.WORD_LEN(32), .ADDR_LEN(5), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_reg    (md_reg),
        .md_data   (md_data),
        .writeEn   (writeEn),
        .writereg  (writereg),
        .writeData (writeData),
        .md_count  (md_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_en    = 1'b0;
        wb_reg   = '0;
        wb_data  = '0;
        md_valid = 1'b0;
        md_reg   = '0;
        md_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if ({writeEn, writereg, writeData} !== {1'b0, 5'd0, 32'h0}) begin
            errors++;
            $display("FAIL reset_port: got %0h expected 0", {writeEn, writereg, writeData});
        end
        checks++;
        if ({md_ready, md_count} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_count: got ready=%0b count=%0d expected ready=0 count=0", md_ready, md_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (md_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b expected 1", md_ready);
        end
        step();
        checks++;
        if ({writeEn, writereg, writeData, md_count} !== {1'b0, 5'd0, 32'h0, 2'd0}) begin
            errors++;
            $display("FAIL idle_after_reset: got %0h expected 0", {writeEn, writereg, writeData, md_count});
        end
    endtask

    task automatic test_pipeline();
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        checks++;
        if ({writeEn, writereg, writeData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL pipe_write: got %0h expected %0h", {writeEn, writereg, writeData}, {1'b1, 5'd5, 32'hDEADBEEF});
        end
        wb_en = 1'b0;
        step();
        checks++;
        if ({writeEn, writereg, writeData} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL pipe_one_cycle_hold: got %0h expected %0h", {writeEn, writereg, writeData}, {1'b0, 5'd5, 32'hDEADBEEF});
        end
        wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'h1234;
        step();
        checks++;
        if ({writeEn, writereg, writeData} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL pipe_reg0: got %0h expected %0h", {writeEn, writereg, writeData}, {1'b0, 5'd5, 32'hDEADBEEF});
        end
        idle_inputs();
    endtask

    task automatic test_buffer_drain();
        wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'h33;
        md_valid = 1'b1; md_reg = 5'd8; md_data = 32'h11;
        step();
        md_reg = 5'd9; md_data = 32'h22;
        checks++;
        if ({md_ready, md_count} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL drain_first_push: got ready=%0b count=%0d expected ready=1 count=1", md_ready, md_count);
        end
        step();
        md_valid = 1'b0;
        checks++;
        if ({md_ready, md_count} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL drain_full: got ready=%0b count=%0d expected ready=0 count=2", md_ready, md_count);
        end
        checks++;
        if ({writeEn, writereg, writeData} !== {1'b1, 5'd3, 32'h33}) begin
            errors++;
            $display("FAIL drain_pipe_wins: got %0h expected %0h", {writeEn, writereg, writeData}, {1'b1, 5'd3, 32'h33});
        end
        step();
        wb_en = 1'b0;
        checks++;
        if ({md_ready, md_count} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL drain_blocked: got ready=%0b count=%0d expected ready=0 count=2", md_ready, md_count);
        end
        step();
        checks++;
        if ({writeEn, writereg, writeData} !== {1'b1, 5'd8, 32'h11}) begin
            errors++;
            $display("FAIL drain_first: got %0h expected %0h", {writeEn, writereg, writeData}, {1'b1, 5'd8, 32'h11});
        end
        checks++;
        if ({md_ready, md_count} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL drain_ready_back: got ready=%0b count=%0d expected ready=1 count=1", md_ready, md_count);
        end
        step();
        checks++;
        if ({writeEn, writereg, writeData, md_count} !== {1'b1, 5'd9, 32'h22, 2'd0}) begin
            errors++;
            $display("FAIL drain_second: got %0h expected %0h", {writeEn, writereg, writeData, md_count}, {1'b1, 5'd9, 32'h22, 2'd0});
        end
        step();
        checks++;
        if (writeEn !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got %0b expected 0", writeEn);
        end
    endtask

    task automatic test_md_latency();
        md_valid = 1'b1; md_reg = 5'd10; md_data = 32'h1010;
        step();
        md_valid = 1'b0;
        checks++;
        if ({writeEn, md_count} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL latency_accept: got en=%0b count=%0d expected en=0 count=1", writeEn, md_count);
        end
        step();
        checks++;
        if ({writeEn, writereg, writeData, md_count} !== {1'b1, 5'd10, 32'h1010, 2'd0}) begin
            errors++;
            $display("FAIL latency_issue: got %0h expected %0h", {writeEn, writereg, writeData, md_count}, {1'b1, 5'd10, 32'h1010, 2'd0});
        end
        step();
    endtask

    task automatic test_kill();
        md_valid = 1'b1; md_reg = 5'd7; md_data = 32'hAA;
        step();
        md_valid = 1'b0;
        wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'hBB;
        step();
        wb_en = 1'b0;
        checks++;
        if ({writeEn, writereg, writeData, md_count} !== {1'b1, 5'd7, 32'hBB, 2'd1}) begin
            errors++;
            $display("FAIL kill_pipe_write: got %0h expected %0h", {writeEn, writereg, writeData, md_count}, {1'b1, 5'd7, 32'hBB, 2'd1});
        end
        step();
        checks++;
        if ({writeEn, writereg, writeData, md_count} !== {1'b0, 5'd7, 32'hBB, 2'd0}) begin
            errors++;
            $display("FAIL kill_dead_pop: got %0h expected %0h", {writeEn, writereg, writeData, md_count}, {1'b0, 5'd7, 32'hBB, 2'd0});
        end
        step();
        checks++;
        if (writeEn !== 1'b0) begin
            errors++;
            $display("FAIL kill_no_late_write: got %0b expected 0", writeEn);
        end
    endtask

    task automatic test_same_edge();
        md_valid = 1'b1; md_reg = 5'd4; md_data = 32'h44;
        wb_en = 1'b1; wb_reg = 5'd4; wb_data = 32'h55;
        step();
        idle_inputs();
        checks++;
        if ({writeEn, writereg, writeData, md_count} !== {1'b1, 5'd4, 32'h55, 2'd1}) begin
            errors++;
            $display("FAIL same_edge_pipe: got %0h expected %0h", {writeEn, writereg, writeData, md_count}, {1'b1, 5'd4, 32'h55, 2'd1});
        end
        step();
        checks++;
        if ({writeEn, writereg, writeData, md_count} !== {1'b1, 5'd4, 32'h44, 2'd0}) begin
            errors++;
            $display("FAIL same_edge_md: got %0h expected %0h", {writeEn, writereg, writeData, md_count}, {1'b1, 5'd4, 32'h44, 2'd0});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'hA0; vals[1] = 32'hA1; vals[2] = 32'hA2;
        md_valid = 1'b1; md_reg = 5'd20; md_data = vals[0];
        step();
        for (int i = 1; i < 4; i++) begin
            if (i < 3) begin
                md_reg = 5'(20 + i); md_data = vals[i];
            end else begin
                md_valid = 1'b0;
            end
            step();
            checks++;
            if ({writeEn, writereg, writeData, md_count} !== {1'b1, 5'(20 + i - 1), vals[i-1], (i < 3) ? 2'd1 : 2'd0}) begin
                errors++;
                $display("FAIL b2b_%0d: got %0h expected %0h", i, {writeEn, writereg, writeData, md_count},
                         {1'b1, 5'(20 + i - 1), vals[i-1], (i < 3) ? 2'd1 : 2'd0});
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        wb_en = 1'b1; wb_reg = 5'd1; wb_data = 32'h1;
        md_valid = 1'b1; md_reg = 5'd12; md_data = 32'hC;
        step();
        md_reg = 5'd13; md_data = 32'hD;
        step();
        md_valid = 1'b0;
        checks++;
        if (md_count !== 2'd2) begin
            errors++;
            $display("FAIL mid_fill: got %0d expected 2", md_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (md_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready_in_reset: got %0b expected 0", md_ready);
        end
        step();
        checks++;
        if ({writeEn, md_count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset_edge: got en=%0b count=%0d expected en=0 count=0", writeEn, md_count);
        end
        rst = 1'b0;
        wb_en = 1'b0;
        step();
        step();
        checks++;
        if (writeEn !== 1'b0) begin
            errors++;
            $display("FAIL mid_discarded: got %0b expected 0", writeEn);
        end
        md_valid = 1'b1; md_reg = 5'd0; md_data = 32'hBAD;
        #1;
        checks++;
        if (md_ready !== 1'b1) begin
            errors++;
            $display("FAIL reg0_ready: got %0b expected 1", md_ready);
        end
        step();
        md_valid = 1'b0;
        checks++;
        if ({writeEn, md_count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reg0_not_queued: got en=%0b count=%0d expected en=0 count=0", writeEn, md_count);
        end
        step();
        checks++;
        if (writeEn !== 1'b0) begin
            errors++;
            $display("FAIL reg0_never_written: got %0b expected 0", writeEn);
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_buffer_drain();
        test_md_latency();
        test_kill();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
